// File: rtl/fetch_queue.sv
// Decoupling FIFO between IF and ID: buffers {inst, pc} pairs, presents the oldest to decode,
// and drops everything on a PC redirect so wrong-path instructions never reach ID.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [31:0]                i_enq_inst,
    input  logic [31:0]                i_enq_pc,
    output logic                       o_deq_valid,
    input  logic                       i_deq_ready,
    output logic [31:0]                o_deq_inst,
    output logic [31:0]                o_deq_pc,
    output logic [31:0]                o_deq_pc_plus_4,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    fq_entry_t         mem [DEPTH];
    fq_entry_t         head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              enq_fire, deq_fire;

    // Ready/valid come only from registered count so no combinational path crosses the queue.
    assign o_enq_ready = (count != CW'(DEPTH));
    assign o_deq_valid = (count != '0);
    assign enq_fire    = i_enq_valid & o_enq_ready;
    assign deq_fire    = o_deq_valid & i_deq_ready;

    assign head            = mem[rd_ptr];
    assign o_deq_inst      = o_deq_valid ? head.inst : NOP_INST;
    assign o_deq_pc        = o_deq_valid ? head.pc   : 32'h0;
    assign o_deq_pc_plus_4 = o_deq_pc + 32'd4;
    assign o_count         = count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a flushed or reset cycle must not write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && enq_fire)
            mem[wr_ptr] <= '{inst: i_enq_inst, pc: i_enq_pc};
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst) count <= CW'(DEPTH));
    a_pc_aligned:  assert property (@(posedge i_clk) disable iff (i_rst) o_deq_valid |-> (o_deq_pc[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, streaming, flush, wrap, full+pop, and mid-stream reset.
module tb_fetch_queue;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_enq_valid = 1'b0;
    logic        o_enq_ready;
    logic [31:0] i_enq_inst = '0;
    logic [31:0] i_enq_pc = '0;
    logic        o_deq_valid;
    logic        i_deq_ready = 1'b0;
    logic [31:0] o_deq_inst;
    logic [31:0] o_deq_pc;
    logic [31:0] o_deq_pc_plus_4;
    logic [2:0]  o_count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .NOP_INST(32'h00000013)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
        .i_enq_inst(i_enq_inst), .i_enq_pc(i_enq_pc),
        .o_deq_valid(o_deq_valid), .i_deq_ready(i_deq_ready),
        .o_deq_inst(o_deq_inst), .o_deq_pc(o_deq_pc),
        .o_deq_pc_plus_4(o_deq_pc_plus_4), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hC0DE0000 | pc;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [31:0] pc);
        i_enq_valid = v;
        i_enq_pc    = pc;
        i_enq_inst  = inst_of(pc);
    endtask

    task automatic push(input logic [31:0] pc);
        drive_enq(1'b1, pc);
        step();
        drive_enq(1'b0, 32'h0);
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, "_cnt"},   32'(o_count), 32'd0);
        chk({tag, "_vld"},   32'(o_deq_valid), 32'd0);
        chk({tag, "_rdy"},   32'(o_enq_ready), 32'd1);
        chk({tag, "_inst"},  o_deq_inst, 32'h00000013);
        chk({tag, "_pc"},    o_deq_pc, 32'h0);
    endtask

    initial begin
        int sent, recv, mcnt;
        logic e, d;

        // reset state
        step();
        i_rst = 1'b0;
        expect_empty("rst");
        chk("rst_pc4", o_deq_pc_plus_4, 32'h4);

        // 1. fill then drain
        push(32'h0);
        chk("t1_lat_cnt", 32'(o_count), 32'd1);
        chk("t1_lat_pc", o_deq_pc, 32'h0);
        for (int k = 1; k < 4; k++) push(32'(4 * k));
        chk("t1_full_cnt", 32'(o_count), 32'd4);
        chk("t1_full_rdy", 32'(o_enq_ready), 32'd0);
        i_deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1_vld",  32'(o_deq_valid), 32'd1);
            chk("t1_pc",   o_deq_pc, 32'(4 * k));
            chk("t1_pc4",  o_deq_pc_plus_4, 32'(4 * k + 4));
            chk("t1_inst", o_deq_inst, inst_of(32'(4 * k)));
            step();
        end
        expect_empty("t1_drained");
        step();  // deq_ready held while empty
        chk("t1_no_underflow", 32'(o_count), 32'd0);
        i_deq_ready = 1'b0;

        // 2. steady stream at count 2
        push(32'h200);
        push(32'h204);
        i_deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_enq(1'b1, 32'(32'h208 + 4 * i));
            chk("t2_cnt", 32'(o_count), 32'd2);
            chk("t2_pc",  o_deq_pc, 32'(32'h200 + 4 * i));
            step();
        end
        drive_enq(1'b0, 32'h0);
        i_deq_ready = 1'b0;
        chk("t2_cnt_end", 32'(o_count), 32'd2);
        chk("t2_pc_end",  o_deq_pc, 32'h220);

        // 3. flush with same-cycle enq/deq
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 3; k++) push(32'(32'h300 + 4 * k));
        chk("t3_cnt3", 32'(o_count), 32'd3);
        i_flush = 1'b1;
        i_deq_ready = 1'b1;
        drive_enq(1'b1, 32'h40);
        step();
        i_flush = 1'b0;
        i_deq_ready = 1'b0;
        drive_enq(1'b0, 32'h0);
        expect_empty("t3_flush");
        step();
        chk("t3_no40_cnt", 32'(o_count), 32'd0);
        chk("t3_no40_pc",  o_deq_pc, 32'h0);

        // 4. wrap-around: 10 entries, pointers start at 0 after the flush
        sent = 0; recv = 0; mcnt = 0;
        for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
            e = (sent < 10);
            d = (mcnt >= 2) || (sent == 10 && mcnt > 0);
            drive_enq(e, 32'(32'h100 + 4 * sent));
            i_deq_ready = d;
            chk("t4_cnt", 32'(o_count), 32'(mcnt));
            if (d) begin
                chk("t4_pc",   o_deq_pc, 32'(32'h100 + 4 * recv));
                chk("t4_inst", o_deq_inst, inst_of(32'(32'h100 + 4 * recv)));
            end
            step();
            if (e) begin sent++; mcnt++; end
            if (d) begin recv++; mcnt--; end
        end
        drive_enq(1'b0, 32'h0);
        i_deq_ready = 1'b0;
        chk("t4_recv", 32'(recv), 32'd10);
        expect_empty("t4_end");

        // 5. full plus pop in same cycle
        for (int k = 0; k < 4; k++) push(32'(32'h500 + 4 * k));
        chk("t5_full", 32'(o_count), 32'd4);
        drive_enq(1'b1, 32'h510);
        i_deq_ready = 1'b1;
        chk("t5_rdy0", 32'(o_enq_ready), 32'd0);
        step();
        i_deq_ready = 1'b0;
        chk("t5_cnt3", 32'(o_count), 32'd3);
        chk("t5_pc",   o_deq_pc, 32'h504);
        chk("t5_rdy1", 32'(o_enq_ready), 32'd1);
        step();
        drive_enq(1'b0, 32'h0);
        chk("t5_cnt4", 32'(o_count), 32'd4);
        i_deq_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("t5_drain", o_deq_pc, 32'(32'h500 + 4 * k));
            step();
        end
        i_deq_ready = 1'b0;
        chk("t5_empty", 32'(o_count), 32'd0);

        // 6. reset mid-stream, with an enq attempt during reset
        for (int k = 0; k < 3; k++) push(32'(32'h600 + 4 * k));
        chk("t6_cnt3", 32'(o_count), 32'd3);
        i_rst = 1'b1;
        drive_enq(1'b1, 32'h700);
        step();
        i_rst = 1'b0;
        drive_enq(1'b0, 32'h0);
        expect_empty("t6_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
